// File: rtl/lfsr_stream_ctrl.sv
// Seeded Galois LFSR stream controller: accepts {seed, count} jobs, emits count words, pulses done.
// Optional LFSR_STALL_CNT_EN adds a saturating backpressure cycle counter (o_stall_cnt).
module lfsr_stream_ctrl #(
  parameter int unsigned       WIDTH = 16,
  parameter logic [WIDTH-1:0]  TAPS  = 16'hB400,
  parameter int unsigned       CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_cfg_valid,
  output logic             o_cfg_ready,
  input  logic [WIDTH-1:0] i_cfg_seed,
  input  logic [CNT_W-1:0] i_cfg_count,
  input  logic             i_abort,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_out_last,
  output logic             o_busy,
  output logic             o_done
`ifdef LFSR_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] o_stall_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_seed;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_lfsr;
  logic [CNT_W-1:0] r_remaining;
  logic             r_out_valid;
  logic             r_out_last;
  logic             r_busy;
  logic             r_done;

  logic             w_fire;
  logic [WIDTH-1:0] w_lfsr_next;

  assign w_fire      = r_out_valid & i_out_ready;
  assign w_lfsr_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : '0);

  assign o_cfg_ready = (r_state == StIdle) && !reset;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_lfsr;
  assign o_out_last  = r_out_last;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_seed      <= '0;
      r_count     <= '0;
      r_lfsr      <= '0;
      r_remaining <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_cfg_valid) begin
            // An all-zero state would lock the LFSR, so substitute all-ones.
            r_seed  <= (i_cfg_seed == '0) ? '1 : i_cfg_seed;
            r_count <= i_cfg_count;
            r_busy  <= 1'b1;
            r_state <= StLoad;
          end
        end
        StLoad: begin
          if (i_abort) begin
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end else begin
            r_lfsr      <= r_seed;
            r_remaining <= r_count;
            if (r_count == '0) begin
              r_done  <= 1'b1;
              r_state <= StDone;
            end else begin
              r_out_valid <= 1'b1;
              r_out_last  <= (r_count == CNT_W'(1));
              r_state     <= StRun;
            end
          end
        end
        StRun: begin
          if (w_fire) begin
            r_lfsr <= w_lfsr_next;
            if (r_remaining != '0) r_remaining <= r_remaining - CNT_W'(1);
            r_out_last <= (r_remaining == CNT_W'(2));
          end
          if (i_abort) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= StIdle;
          end else if (w_fire && r_out_last) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= StDone;
          end
        end
        StDone: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

`ifdef LFSR_STALL_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset || (r_state == StIdle && i_cfg_valid)) begin
      r_stall_cnt <= '0;
    end else if (r_state == StRun && r_out_valid && !i_out_ready && r_stall_cnt != '1) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_lfsr_stream_ctrl.sv
// Directed bench for lfsr_stream_ctrl: table of jobs plus hand-written multi-cycle sequences.
module tb_lfsr_stream_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_seed;
  logic [15:0] cfg_count;
  logic        abort;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;
`ifdef LFSR_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  lfsr_stream_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .i_cfg_valid (cfg_valid),
    .o_cfg_ready (cfg_ready),
    .i_cfg_seed  (cfg_seed),
    .i_cfg_count (cfg_count),
    .i_abort     (abort),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (out_data),
    .o_out_last  (out_last),
    .o_busy      (busy),
    .o_done      (done)
`ifdef LFSR_STALL_CNT_EN
    ,
    .o_stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]      seed;
    logic [15:0]      count;
    logic [3:0][15:0] words;
  } job_t;

  job_t jobs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Full job with out_ready held high; checks cycle-exact latency, data, last and done.
  task automatic run_job(input job_t j);
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_seed  = j.seed;
    cfg_count = j.count;
    chk("accept_ready", 32'(cfg_ready), 32'd1);
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("load_valid", 32'(out_valid), 32'd0);
    chk("load_busy", 32'(busy), 32'd1);
    for (int k = 0; k < int'(j.count); k++) begin
      @(negedge clk);
      chk("word_valid", 32'(out_valid), 32'd1);
      chk("word_data", 32'(out_data), 32'(j.words[k]));
      chk("word_last", 32'(out_last), 32'(k == int'(j.count) - 1));
      chk("word_done", 32'(done), 32'd0);
    end
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_valid", 32'(out_valid), 32'd0);
    chk("done_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("after_done", 32'(done), 32'd0);
    chk("after_ready", 32'(cfg_ready), 32'd1);
    chk("after_busy", 32'(busy), 32'd0);
  endtask

  task automatic accept(input logic [15:0] seed, input logic [15:0] count);
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_seed  = seed;
    cfg_count = count;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    cfg_valid = 1'b0;
    cfg_seed  = '0;
    cfg_count = '0;
    abort     = 1'b0;
    out_ready = 1'b1;

    jobs[0] = '{16'hACE1, 16'd3, {16'h0000, 16'h7138, 16'hE270, 16'hACE1}};
    jobs[1] = '{16'h0001, 16'd2, {16'h0000, 16'h0000, 16'hB400, 16'h0001}};
    jobs[2] = '{16'h0000, 16'd1, {16'h0000, 16'h0000, 16'h0000, 16'hFFFF}};
    jobs[3] = '{16'hACE1, 16'd0, {16'h0000, 16'h0000, 16'h0000, 16'h0000}};
    jobs[4] = '{16'hFFFF, 16'd2, {16'h0000, 16'h0000, 16'hCBFF, 16'hFFFF}};
    jobs[5] = '{16'h8000, 16'd2, {16'h0000, 16'h0000, 16'h4000, 16'h8000}};

    repeat (3) @(negedge clk);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(cfg_ready), 32'd1);

    for (int i = 0; i < 6; i++) run_job(jobs[i]);

    // Backpressure: word 2 held for three cycles.
    accept(16'hACE1, 16'd3);
    @(negedge clk);
    chk("bp_w1", 32'(out_data), 32'hACE1);
    @(negedge clk);
    chk("bp_w2a", 32'(out_data), 32'hE270);
    out_ready = 1'b0;
    @(negedge clk);
    chk("bp_w2b", 32'(out_data), 32'hE270);
    chk("bp_w2b_valid", 32'(out_valid), 32'd1);
    chk("bp_w2b_last", 32'(out_last), 32'd0);
    @(negedge clk);
    chk("bp_w2c", 32'(out_data), 32'hE270);
    chk("bp_w2c_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_w3", 32'(out_data), 32'h7138);
    chk("bp_w3_last", 32'(out_last), 32'd1);
    @(negedge clk);
    chk("bp_done", 32'(done), 32'd1);
    chk("bp_no_extra", 32'(out_valid), 32'd0);
`ifdef LFSR_STALL_CNT_EN
    chk("bp_stall_cnt", 32'(stall_cnt), 32'd2);
`endif
    @(negedge clk);
`ifdef LFSR_STALL_CNT_EN
    chk("bp_stall_hold", 32'(stall_cnt), 32'd2);
`endif

    // Abort coinciding with the handshake of word 2.
    accept(16'hACE1, 16'd10);
    @(negedge clk);
    chk("ab_w1", 32'(out_data), 32'hACE1);
    @(negedge clk);
    chk("ab_w2", 32'(out_data), 32'hE270);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_valid", 32'(out_valid), 32'd0);
    chk("ab_done", 32'(done), 32'd0);
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_ready", 32'(cfg_ready), 32'd1);
    @(negedge clk);
    chk("ab_no_done", 32'(done), 32'd0);
    chk("ab_valid2", 32'(out_valid), 32'd0);

    // Reset in the middle of a job, then a fresh job.
    accept(16'hACE1, 16'd5);
    @(negedge clk);
    @(negedge clk);
    chk("mr_w2", 32'(out_data), 32'hE270);
    reset = 1'b1;
    @(negedge clk);
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_done", 32'(done), 32'd0);
    chk("mr_cfg_ready", 32'(cfg_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("mr_no_done", 32'(done), 32'd0);
    chk("mr_idle_ready", 32'(cfg_ready), 32'd1);
    run_job(jobs[1]);

    // Back-to-back: cfg_valid stays high, second job accepted in the IDLE cycle after done.
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_seed  = 16'hACE1;
    cfg_count = 16'd1;
    @(negedge clk);
    cfg_seed  = 16'h0001;
    cfg_count = 16'd2;
    chk("bb_load_ready", 32'(cfg_ready), 32'd0);
    @(negedge clk);
    chk("bb_a_data", 32'(out_data), 32'hACE1);
    chk("bb_a_last", 32'(out_last), 32'd1);
    @(negedge clk);
    chk("bb_a_done", 32'(done), 32'd1);
    chk("bb_done_ready", 32'(cfg_ready), 32'd0);
    @(negedge clk);
    chk("bb_idle_ready", 32'(cfg_ready), 32'd1);
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("bb_b_load_busy", 32'(busy), 32'd1);
    chk("bb_b_load_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("bb_b_w1", 32'(out_data), 32'h0001);
    chk("bb_b_w1_last", 32'(out_last), 32'd0);
    @(negedge clk);
    chk("bb_b_w2", 32'(out_data), 32'hB400);
    chk("bb_b_w2_last", 32'(out_last), 32'd1);
    @(negedge clk);
    chk("bb_b_done", 32'(done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
